// File: rtl/alu_issue_arbiter.sv
// Two-requester round-robin issue arbiter feeding a single-entry ALU output register,
// with per-requester saturating grant counters.
module alu_issue_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             _clear,
  input  logic             _req0_valid,
  input  logic [4:0]       _req0_rob_id,
  input  logic [6:0]       _req0_type,
  input  logic [3:0]       _req0_op,
  input  logic [31:0]      _req0_v1,
  input  logic [31:0]      _req0_v2,
  output logic             _req0_grant,
  input  logic             _req1_valid,
  input  logic [4:0]       _req1_rob_id,
  input  logic [6:0]       _req1_type,
  input  logic [3:0]       _req1_op,
  input  logic [31:0]      _req1_v1,
  input  logic [31:0]      _req1_v2,
  output logic             _req1_grant,
  input  logic             _alu_full,
  output logic             _alu_ready,
  output logic [4:0]       _alu_rob_id,
  output logic [6:0]       _alu_type,
  output logic [3:0]       _alu_op,
  output logic [31:0]      _alu_v1,
  output logic [31:0]      _alu_v2,
  output logic [CNT_W-1:0] _grant_cnt0,
  output logic [CNT_W-1:0] _grant_cnt1
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_aluReady;
  logic [4:0]       r_aluRobId;
  logic [6:0]       r_aluType;
  logic [3:0]       r_aluOp;
  logic [31:0]      r_aluV1;
  logic [31:0]      r_aluV2;
  logic             r_lastGrant;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_grantEn;
  logic w_grant0;
  logic w_grant1;
  logic w_drain;

  // Reset is folded into the enable so grants stay low while rst_in is held low.
  assign w_grantEn = rst_in & rdy_in & ~_clear & (~r_aluReady | ~_alu_full);
  assign w_grant0  = w_grantEn & _req0_valid & (~_req1_valid | r_lastGrant);
  assign w_grant1  = w_grantEn & _req1_valid & (~_req0_valid | ~r_lastGrant);
  assign w_drain   = r_aluReady & ~_alu_full;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_aluReady  <= 1'b0;
      r_aluRobId  <= '0;
      r_aluType   <= '0;
      r_aluOp     <= '0;
      r_aluV1     <= '0;
      r_aluV2     <= '0;
      r_lastGrant <= 1'b1;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else if (rdy_in) begin
      if (_clear) begin
        r_aluReady <= 1'b0;
      end else if (w_grant0) begin
        r_aluReady  <= 1'b1;
        r_aluRobId  <= _req0_rob_id;
        r_aluType   <= _req0_type;
        r_aluOp     <= _req0_op;
        r_aluV1     <= _req0_v1;
        r_aluV2     <= _req0_v2;
        r_lastGrant <= 1'b0;
        if (r_cnt0 != '1) r_cnt0 <= r_cnt0 + CntOne;
      end else if (w_grant1) begin
        r_aluReady  <= 1'b1;
        r_aluRobId  <= _req1_rob_id;
        r_aluType   <= _req1_type;
        r_aluOp     <= _req1_op;
        r_aluV1     <= _req1_v1;
        r_aluV2     <= _req1_v2;
        r_lastGrant <= 1'b1;
        if (r_cnt1 != '1) r_cnt1 <= r_cnt1 + CntOne;
      end else if (w_drain) begin
        r_aluReady <= 1'b0;
      end
    end
  end

  assign _req0_grant = w_grant0;
  assign _req1_grant = w_grant1;
  assign _alu_ready  = r_aluReady;
  assign _alu_rob_id = r_aluRobId;
  assign _alu_type   = r_aluType;
  assign _alu_op     = r_aluOp;
  assign _alu_v1     = r_aluV1;
  assign _alu_v2     = r_aluV2;
  assign _grant_cnt0 = r_cnt0;
  assign _grant_cnt1 = r_cnt1;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: cycle model plus an issue scoreboard,
// with a second CNT_W=2 instance sharing the inputs to exercise counter saturation.
module tb_alu_issue_arbiter;

  typedef struct {
    logic [4:0]  robId;
    logic [6:0]  typ;
    logic [3:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
  } entry_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in, rdy_in, clearIn, aluFull;
  logic        req0Valid, req1Valid;
  logic [4:0]  req0RobId, req1RobId;
  logic [6:0]  req0Type, req1Type;
  logic [3:0]  req0Op, req1Op;
  logic [31:0] req0V1, req0V2, req1V1, req1V2;

  logic        grant0, grant1, aluReady;
  logic [4:0]  aluRobId;
  logic [6:0]  aluType;
  logic [3:0]  aluOp;
  logic [31:0] aluV1, aluV2;
  logic [15:0] cnt0, cnt1;

  logic        sGrant0, sGrant1, sReady;
  logic [4:0]  sRobId;
  logic [6:0]  sType;
  logic [3:0]  sOp;
  logic [31:0] sV1, sV2;
  logic [1:0]  sCnt0, sCnt1;

  alu_issue_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(clearIn),
    ._req0_valid(req0Valid), ._req0_rob_id(req0RobId), ._req0_type(req0Type),
    ._req0_op(req0Op), ._req0_v1(req0V1), ._req0_v2(req0V2), ._req0_grant(grant0),
    ._req1_valid(req1Valid), ._req1_rob_id(req1RobId), ._req1_type(req1Type),
    ._req1_op(req1Op), ._req1_v1(req1V1), ._req1_v2(req1V2), ._req1_grant(grant1),
    ._alu_full(aluFull), ._alu_ready(aluReady), ._alu_rob_id(aluRobId),
    ._alu_type(aluType), ._alu_op(aluOp), ._alu_v1(aluV1), ._alu_v2(aluV2),
    ._grant_cnt0(cnt0), ._grant_cnt1(cnt1)
  );

  alu_issue_arbiter #(.CNT_W(2)) dutSat (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(clearIn),
    ._req0_valid(req0Valid), ._req0_rob_id(req0RobId), ._req0_type(req0Type),
    ._req0_op(req0Op), ._req0_v1(req0V1), ._req0_v2(req0V2), ._req0_grant(sGrant0),
    ._req1_valid(req1Valid), ._req1_rob_id(req1RobId), ._req1_type(req1Type),
    ._req1_op(req1Op), ._req1_v1(req1V1), ._req1_v2(req1V2), ._req1_grant(sGrant1),
    ._alu_full(aluFull), ._alu_ready(sReady), ._alu_rob_id(sRobId),
    ._alu_type(sType), ._alu_op(sOp), ._alu_v1(sV1), ._alu_v2(sV2),
    ._grant_cnt0(sCnt0), ._grant_cnt1(sCnt1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state and the scoreboard of issued-but-not-drained entries.
  logic   mReady, mLast;
  int     mCnt0, mCnt1, mSat0, mSat1;
  entry_t expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mReady = 1'b0;
    mLast  = 1'b1;
    mCnt0  = 0;
    mCnt1  = 0;
    mSat0  = 0;
    mSat1  = 0;
    expQ.delete();
  endtask

  task automatic checkHeld();
    checkOutput("ready", {31'b0, aluReady}, {31'b0, mReady});
    checkOutput("cnt0", {16'b0, cnt0}, mCnt0);
    checkOutput("cnt1", {16'b0, cnt1}, mCnt1);
    checkOutput("satCnt0", {30'b0, sCnt0}, mSat0);
    checkOutput("satCnt1", {30'b0, sCnt1}, mSat1);
    if (mReady && expQ.size() > 0) begin
      checkOutput("heldRob", {27'b0, aluRobId}, {27'b0, expQ[0].robId});
      checkOutput("heldType", {25'b0, aluType}, {25'b0, expQ[0].typ});
      checkOutput("heldOp", {28'b0, aluOp}, {28'b0, expQ[0].op});
      checkOutput("heldV1", aluV1, expQ[0].v1);
      checkOutput("heldV2", aluV2, expQ[0].v2);
    end
  endtask

  // One clock of stimulus: drive at negedge, check grants and drains before the edge,
  // then advance the model and check registered state after the edge.
  task automatic applyStimulus(input logic rdy, input logic clr, input logic full,
                               input logic v0, input logic v1,
                               input logic [4:0] rob0, input logic [4:0] rob1);
    logic   en, eg0, eg1, drain;
    entry_t e;
    @(negedge clk_in);
    rdy_in    = rdy;
    clearIn   = clr;
    aluFull   = full;
    req0Valid = v0;
    req1Valid = v1;
    req0RobId = rob0;
    req1RobId = rob1;
    req0Type  = 7'($urandom);
    req1Type  = 7'($urandom);
    req0Op    = 4'($urandom);
    req1Op    = 4'($urandom);
    req0V1    = $urandom;
    req0V2    = $urandom;
    req1V1    = $urandom;
    req1V2    = $urandom;
    #2;
    en    = rdy & ~clr & (~mReady | ~full);
    eg0   = en & v0 & (~v1 | mLast);
    eg1   = en & v1 & (~v0 | ~mLast);
    drain = rdy & ~clr & mReady & ~full;
    checkOutput("grant0", {31'b0, grant0}, {31'b0, eg0});
    checkOutput("grant1", {31'b0, grant1}, {31'b0, eg1});
    checkOutput("satGrant0", {31'b0, sGrant0}, {31'b0, eg0});
    if (drain && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("drainRob", {27'b0, aluRobId}, {27'b0, e.robId});
      checkOutput("drainV2", aluV2, e.v2);
    end
    @(posedge clk_in);
    #1;
    if (rdy) begin
      if (clr) begin
        mReady = 1'b0;
        expQ.delete();
      end else if (eg0 || eg1) begin
        e.robId = eg0 ? rob0 : rob1;
        e.typ   = eg0 ? req0Type : req1Type;
        e.op    = eg0 ? req0Op : req1Op;
        e.v1    = eg0 ? req0V1 : req1V1;
        e.v2    = eg0 ? req0V2 : req1V2;
        expQ.push_back(e);
        mReady = 1'b1;
        mLast  = eg1;
        if (eg0) begin
          if (mCnt0 < 65535) mCnt0++;
          if (mSat0 < 3) mSat0++;
        end else begin
          if (mCnt1 < 65535) mCnt1++;
          if (mSat1 < 3) mSat1++;
        end
      end else if (drain) begin
        mReady = 1'b0;
      end
    end
    checkHeld();
  endtask

  // Asynchronous reset asserted between edges with requests pending.
  task automatic doReset();
    @(negedge clk_in);
    req0Valid = 1'b1;
    req1Valid = 1'b1;
    rdy_in    = 1'b1;
    clearIn   = 1'b0;
    aluFull   = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    modelReset();
    checkOutput("rstReady", {31'b0, aluReady}, 32'd0);
    checkOutput("rstRob", {27'b0, aluRobId}, 32'd0);
    checkOutput("rstV1", aluV1, 32'd0);
    checkOutput("rstCnt0", {16'b0, cnt0}, 32'd0);
    checkOutput("rstGrant0", {31'b0, grant0}, 32'd0);
    checkOutput("rstGrant1", {31'b0, grant1}, 32'd0);
    @(posedge clk_in);
    #1;
    checkOutput("rstHoldReady", {31'b0, aluReady}, 32'd0);
    checkOutput("rstHoldGrant0", {31'b0, grant0}, 32'd0);
    @(negedge clk_in);
    rst_in    = 1'b1;
    req0Valid = 1'b0;
    req1Valid = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clearIn = 1'b0; aluFull = 1'b0;
    req0Valid = 1'b0; req1Valid = 1'b0;
    req0RobId = '0; req1RobId = '0; req0Type = '0; req1Type = '0;
    req0Op = '0; req1Op = '0; req0V1 = '0; req0V2 = '0; req1V1 = '0; req1V2 = '0;
    modelReset();
    doReset();

    // Contention: grants alternate starting with requester 0.
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1, 1, 5'(10 + i), 5'(20 + i));
    checkOutput("contCnt0", {16'b0, cnt0}, 32'd2);
    checkOutput("contCnt1", {16'b0, cnt1}, 32'd2);
    checkOutput("contLastRob", {27'b0, aluRobId}, 32'd23);

    // Flush while holding an entry, then contention resumes from the unchanged last grant.
    applyStimulus(1, 1, 0, 1, 1, 5'd1, 5'd2);
    applyStimulus(1, 0, 0, 1, 1, 5'd3, 5'd4);
    checkOutput("flushNextRob", {27'b0, aluRobId}, 32'd3);

    // Pause with pending requests, also while _clear is high.
    applyStimulus(0, 0, 0, 1, 1, 5'd7, 5'd8);
    applyStimulus(0, 1, 0, 1, 1, 5'd7, 5'd8);
    applyStimulus(1, 0, 0, 1, 1, 5'd9, 5'd11);
    applyStimulus(1, 0, 0, 1, 1, 5'd12, 5'd13);

    // Backpressure on a single request.
    applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0);
    applyStimulus(1, 0, 0, 1, 0, 5'd5, 5'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 1, 0, 5'd6, 5'd0);
    checkOutput("bpHeldRob", {27'b0, aluRobId}, 32'd5);
    applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0);
    checkOutput("bpDrained", {31'b0, aluReady}, 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 40; i++)
      applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
                    1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom));

    // Async reset while an entry is held, then requester 0 wins the first contention.
    applyStimulus(1, 0, 1, 1, 0, 5'd17, 5'd0);
    doReset();
    applyStimulus(1, 0, 0, 1, 1, 5'd25, 5'd26);
    checkOutput("postRstRob", {27'b0, aluRobId}, 32'd25);

    // Saturation of the 2-bit counter instance.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 1, 0, 5'(i), 5'd0);
    checkOutput("satStop", {30'b0, sCnt0}, 32'd3);
    checkOutput("wideCnt", {16'b0, cnt0}, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
